// File: rtl/seg_scan_if.sv
// Bus bundle between the peripheral block and the seven-segment scan controller.
// The master side drives value/dp/load and the raw register; the slave side drives the pins.
interface seg_scan_if;
    logic [11:0] raw_digi;
    logic        raw_mode;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic        pending;
    logic        frame_tick;
    logic [3:0]  an;
    logic [7:0]  seg;

    modport master (
        output raw_digi, raw_mode, value, dp, load,
        input  pending, frame_tick, an, seg
    );

    modport slave (
        input  raw_digi, raw_mode, value, dp, load,
        output pending, frame_tick, an, seg
    );
endinterface

// File: rtl/seg_scan.sv
// Four-digit common-anode seven-segment scanner with frame-boundary double buffering and a raw pass-through mode.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking on digits 3..1.
module seg_scan #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic      clk,
    input  logic      reset,
    seg_scan_if.slave bus
);

    typedef enum logic [1:0] {D0, D1, D2, D3} state_t;

    localparam logic [31:0] TC_VAL = 32'(SCAN_DIV - 1);

    logic [31:0] cnt;
    state_t      state;
    state_t      next_state;
    logic [15:0] pend_val;
    logic [3:0]  pend_dp;
    logic [15:0] act_val;
    logic [3:0]  act_dp;
    logic        fb_q;
    logic        tc;
    logic        fb;
    logic [1:0]  dig;
    logic [3:0]  nib;
    logic        blank;
    logic [3:0]  scan_an;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    return 7'h40;
            4'h1:    return 7'h79;
            4'h2:    return 7'h24;
            4'h3:    return 7'h30;
            4'h4:    return 7'h19;
            4'h5:    return 7'h12;
            4'h6:    return 7'h02;
            4'h7:    return 7'h78;
            4'h8:    return 7'h00;
            4'h9:    return 7'h10;
            4'hA:    return 7'h08;
            4'hB:    return 7'h03;
            4'hC:    return 7'h46;
            4'hD:    return 7'h21;
            4'hE:    return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    always_comb begin
        tc         = (cnt == TC_VAL);
        fb         = tc && (state == D3);
        dig        = state;
        next_state = D0;
        nib        = act_val[3:0];
        case (state)
            D0: begin next_state = D1; nib = act_val[3:0];   end
            D1: begin next_state = D2; nib = act_val[7:4];   end
            D2: begin next_state = D3; nib = act_val[11:8];  end
            D3: begin next_state = D0; nib = act_val[15:12]; end
            default: ;
        endcase
    end

`ifdef SEG_SCAN_LZB_EN
    // A digit blanks only if it and every higher nibble are zero and its point is off.
    always_comb begin
        blank = 1'b0;
        case (state)
            D1: blank = (act_val[15:4] == 12'h000) && !act_dp[1];
            D2: blank = (act_val[15:8] == 8'h00) && !act_dp[2];
            D3: blank = (act_val[15:12] == 4'h0) && !act_dp[3];
            default: blank = 1'b0;
        endcase
    end
`else
    always_comb blank = 1'b0;
`endif

    always_comb scan_an = blank ? 4'hF : ~(4'b0001 << dig);

    // Pins are driven from the pre-edge digit/data, so they trail the FSM by one cycle;
    // frame_tick is delayed twice so it coincides with D0 first showing on the anodes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt            <= 32'd0;
            state          <= D0;
            pend_val       <= 16'h0000;
            pend_dp        <= 4'h0;
            act_val        <= 16'h0000;
            act_dp         <= 4'h0;
            fb_q           <= 1'b0;
            bus.pending    <= 1'b0;
            bus.frame_tick <= 1'b0;
            bus.an         <= 4'hF;
            bus.seg        <= 8'hFF;
        end else begin
            cnt <= tc ? 32'd0 : cnt + 32'd1;
            if (tc)
                state <= next_state;

            if (fb) begin
                if (bus.load) begin
                    act_val <= bus.value;
                    act_dp  <= bus.dp;
                end else if (bus.pending) begin
                    act_val <= pend_val;
                    act_dp  <= pend_dp;
                end
                bus.pending <= 1'b0;
            end else if (bus.load) begin
                pend_val    <= bus.value;
                pend_dp     <= bus.dp;
                bus.pending <= 1'b1;
            end

            fb_q           <= fb;
            bus.frame_tick <= fb_q;

            if (bus.raw_mode) begin
                bus.an  <= bus.raw_digi[11:8];
                bus.seg <= bus.raw_digi[7:0];
            end else begin
                bus.an  <= scan_an;
                bus.seg <= {~act_dp[dig], hex7(nib)};
            end
        end
    end

endmodule
